// File: rtl/control_sequencer_if.sv
// Control bus between the instruction sequencer (master) and the datapath (slave).
// Carries run/IR/memory-ready status in and every datapath strobe out.
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
  logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] R_in;
  logic [15:0] R_out;
  logic [4:0]  ALU_Control;
  logic        busy, halted, instr_done, illegal;

  modport master (
    input  run, ir, mem_ready,
    output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
           Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
           R_in, R_out, ALU_Control, busy, halted, instr_done, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
           Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
           R_in, R_out, ALU_Control, busy, halted, instr_done, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the datapath strobes.
// Define MULDIV_EN to enable the MUL/DIV opcodes and the T6 HI/LO writeback step.
module control_sequencer (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t     state, state_nxt;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv;
  logic       unused_ir;

  assign opcode    = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];
  assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01101);
`ifdef MULDIV_EN
  assign is_muldiv = (opcode == 5'b01110) || (opcode == 5'b01111);
`else
  assign is_muldiv = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs decode from state (and IR fields); only T1 looks at mem_ready.
  always_comb begin
    state_nxt       = state;
    bus.PCout       = 1'b0;
    bus.MARin       = 1'b0;
    bus.IncPC       = 1'b0;
    bus.Zin         = 1'b0;
    bus.Zlowout     = 1'b0;
    bus.Zhighout    = 1'b0;
    bus.PCin        = 1'b0;
    bus.Read        = 1'b0;
    bus.MDRin       = 1'b0;
    bus.MDRout      = 1'b0;
    bus.IRin        = 1'b0;
    bus.Yin         = 1'b0;
    bus.HIin        = 1'b0;
    bus.LOin        = 1'b0;
    bus.R_in        = 16'h0000;
    bus.R_out       = 16'h0000;
    bus.ALU_Control = 5'b00000;
    bus.busy        = (state != IDLE) && (state != HALT);
    bus.halted      = (state == HALT);
    bus.instr_done  = 1'b0;
    bus.illegal     = 1'b0;
    case (state)
      IDLE: if (bus.run) state_nxt = T0;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_nxt = T1;
      end
      T1: begin
        bus.Read = 1'b1;
        if (bus.mem_ready) begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
          bus.MDRin   = 1'b1;
          state_nxt   = T2;
        end
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_nxt  = T3;
      end
      T3: begin
        if (is_alu || is_muldiv) begin
          bus.R_out = 16'h0001 << rb;
          bus.Yin   = 1'b1;
          state_nxt = T4;
        end else if (opcode == 5'b11010) begin
          bus.instr_done = 1'b1;
          state_nxt      = T0;
        end else if (opcode == 5'b11011) begin
          bus.instr_done = 1'b1;
          state_nxt      = HALT;
        end else begin
          bus.illegal = 1'b1;
          state_nxt   = T0;
        end
      end
      T4: begin
        bus.R_out       = 16'h0001 << rc;
        bus.Zin         = 1'b1;
        bus.ALU_Control = opcode;
        state_nxt       = T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
`ifdef MULDIV_EN
        if (is_muldiv) begin
          bus.LOin  = 1'b1;
          state_nxt = T6;
        end else begin
          bus.R_in       = 16'h0001 << ra;
          bus.instr_done = 1'b1;
          state_nxt      = T0;
        end
`else
        bus.R_in       = 16'h0001 << ra;
        bus.instr_done = 1'b1;
        state_nxt      = T0;
`endif
      end
`ifdef MULDIV_EN
      T6: begin
        bus.Zhighout   = 1'b1;
        bus.HIin       = 1'b1;
        bus.instr_done = 1'b1;
        state_nxt      = T0;
      end
`endif
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle vector table plus hand-written halt sequence,
// expected outputs queued as each cycle's stimulus is applied.
module tb_control_sequencer;

  typedef struct packed {
    logic [13:0] stb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        busy;
    logic        halted;
    logic        done;
    logic        ill;
  } out_t;

  typedef struct {
    string       tag;
    logic        run;
    logic        mr;
    logic        clr;
    logic [31:0] ir;
    out_t        exp;
  } vec_t;

  localparam logic [13:0] S_PCOUT = 14'h2000, S_MARIN = 14'h1000, S_INCPC = 14'h0800;
  localparam logic [13:0] S_ZIN   = 14'h0400, S_ZLOW  = 14'h0200, S_ZHIGH = 14'h0100;
  localparam logic [13:0] S_PCIN  = 14'h0080, S_READ  = 14'h0040, S_MDRIN = 14'h0020;
  localparam logic [13:0] S_MDROUT = 14'h0010, S_IRIN = 14'h0008, S_YIN   = 14'h0004;
  localparam logic [13:0] S_HIIN  = 14'h0002, S_LOIN  = 14'h0001;

  localparam logic [31:0] IR_ADD  = {5'b00011, 4'd3,  4'd1, 4'd2,  15'd0};
  localparam logic [31:0] IR_OP13 = {5'b01101, 4'd15, 4'd0, 4'd14, 15'd0};
  localparam logic [31:0] IR_BAD  = {5'b11111, 4'd1,  4'd2, 4'd3,  15'd0};
  localparam logic [31:0] IR_LOW  = {5'b00010, 4'd1,  4'd2, 4'd3,  15'd0};
  localparam logic [31:0] IR_NOP  = {5'b11010, 4'd0,  4'd0, 4'd0,  15'd0};
  localparam logic [31:0] IR_HALT = {5'b11011, 4'd0,  4'd0, 4'd0,  15'd0};
  localparam logic [31:0] IR_MUL  = {5'b01110, 4'd0,  4'd4, 4'd5,  15'd0};

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   total = 0;
  int   bad   = 0;
  out_t sb[$];
  vec_t tbl[$];

  control_sequencer_if bus ();
  control_sequencer dut (.clock(clock), .clear(clear), .bus(bus.master));

  always #5 clock = ~clock;

  function automatic out_t mk(logic [13:0] s, logic [15:0] rin, logic [15:0] rout,
                              logic [4:0] alu, logic bz, logic hl, logic dn, logic il);
    out_t o;
    o.stb = s; o.rin = rin; o.rout = rout; o.alu = alu;
    o.busy = bz; o.halted = hl; o.done = dn; o.ill = il;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.stb = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.Zhighout, bus.PCin,
             bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.HIin, bus.LOin};
    o.rin = bus.R_in; o.rout = bus.R_out; o.alu = bus.ALU_Control;
    o.busy = bus.busy; o.halted = bus.halted; o.done = bus.instr_done; o.ill = bus.illegal;
    return o;
  endfunction

  function automatic void row(string tag, logic r, logic m, logic c, logic [31:0] i, out_t e);
    vec_t v;
    v.tag = tag; v.run = r; v.mr = m; v.clr = c; v.ir = i; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic void fetch(string tag, logic [31:0] i);
    row({tag, "_t0"}, 1'b0, 1'b1, 1'b0, i, mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 1, 0, 0, 0));
    row({tag, "_t1"}, 1'b0, 1'b1, 1'b0, i, mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, 1, 0, 0, 0));
    row({tag, "_t2"}, 1'b0, 1'b1, 1'b0, i, mk(S_MDROUT | S_IRIN, 0, 0, 0, 1, 0, 0, 0));
  endfunction

  task automatic step(string tag, logic r, logic m, logic c, logic [31:0] i, out_t e);
    out_t got, exp;
    bus.run = r; bus.mem_ready = m; bus.ir = i; clear = c;
    sb.push_back(e);
    @(negedge clock);
    got = sample();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got=%h", tag, got);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        bad++;
        $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    out_t zero;
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0);
    bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = 32'd0;

    row("rst_idle", 0, 0, 0, 32'd0, zero);
    row("idle_hold", 0, 1, 0, 32'd0, zero);
    row("idle_run", 1, 0, 0, IR_ADD, zero);
    fetch("add", IR_ADD);
    row("add_t3", 0, 1, 0, IR_ADD, mk(S_YIN, 0, 16'h0002, 0, 1, 0, 0, 0));
    row("add_t4", 0, 1, 0, IR_ADD, mk(S_ZIN, 0, 16'h0004, 5'b00011, 1, 0, 0, 0));
    row("add_t5", 0, 1, 0, IR_ADD, mk(S_ZLOW, 16'h0008, 0, 0, 1, 0, 1, 0));

    row("op13_t0", 0, 0, 0, IR_OP13, mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      row("op13_stall", 0, 0, 0, IR_OP13, mk(S_READ, 0, 0, 0, 1, 0, 0, 0));
    row("op13_t1", 0, 1, 0, IR_OP13, mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, 1, 0, 0, 0));
    row("op13_t2", 0, 1, 0, IR_OP13, mk(S_MDROUT | S_IRIN, 0, 0, 0, 1, 0, 0, 0));
    row("op13_t3", 0, 1, 0, IR_OP13, mk(S_YIN, 0, 16'h0001, 0, 1, 0, 0, 0));
    row("op13_t4", 0, 1, 0, IR_OP13, mk(S_ZIN, 0, 16'h4000, 5'b01101, 1, 0, 0, 0));
    row("op13_t5", 0, 1, 0, IR_OP13, mk(S_ZLOW, 16'h8000, 0, 0, 1, 0, 1, 0));

    fetch("bad", IR_BAD);
    row("bad_t3", 0, 1, 0, IR_BAD, mk(0, 0, 0, 0, 1, 0, 0, 1));
    fetch("low", IR_LOW);
    row("low_t3", 0, 1, 0, IR_LOW, mk(0, 0, 0, 0, 1, 0, 0, 1));
    fetch("nop", IR_NOP);
    row("nop_t3", 0, 1, 0, IR_NOP, mk(0, 0, 0, 0, 1, 0, 1, 0));

    fetch("mul", IR_MUL);
`ifdef MULDIV_EN
    row("mul_t3", 0, 1, 0, IR_MUL, mk(S_YIN, 0, 16'h0010, 0, 1, 0, 0, 0));
    row("mul_t4", 0, 1, 0, IR_MUL, mk(S_ZIN, 0, 16'h0020, 5'b01110, 1, 0, 0, 0));
    row("mul_t5", 0, 1, 0, IR_MUL, mk(S_ZLOW | S_LOIN, 0, 0, 0, 1, 0, 0, 0));
    row("mul_t6", 0, 1, 0, IR_MUL, mk(S_ZHIGH | S_HIIN, 0, 0, 0, 1, 0, 1, 0));
`else
    row("mul_t3", 0, 1, 0, IR_MUL, mk(0, 0, 0, 0, 1, 0, 0, 1));
`endif

    fetch("clr", IR_ADD);
    row("clr_t3", 0, 1, 0, IR_ADD, mk(S_YIN, 0, 16'h0002, 0, 1, 0, 0, 0));
    row("clr_t4", 0, 1, 1, IR_ADD, mk(S_ZIN, 0, 16'h0004, 5'b00011, 1, 0, 0, 0));
    row("clr_idle", 0, 1, 0, IR_ADD, zero);
    row("clr_run", 1, 1, 0, IR_ADD, zero);
    row("clr_t0", 0, 0, 0, IR_ADD, mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 1, 0, 0, 0));
    row("clr_stall", 0, 0, 1, IR_ADD, mk(S_READ, 0, 0, 0, 1, 0, 0, 0));
    row("clr_idle2", 0, 1, 0, IR_ADD, zero);

    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    foreach (tbl[n])
      step(tbl[n].tag, tbl[n].run, tbl[n].mr, tbl[n].clr, tbl[n].ir, tbl[n].exp);

    // Halt path: done pulse in T3, then parked in HALT regardless of run until clear.
    step("halt_run", 1, 1, 0, IR_HALT, zero);
    step("halt_t0", 0, 1, 0, IR_HALT, mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 1, 0, 0, 0));
    step("halt_t1", 0, 1, 0, IR_HALT, mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, 1, 0, 0, 0));
    step("halt_t2", 0, 1, 0, IR_HALT, mk(S_MDROUT | S_IRIN, 0, 0, 0, 1, 0, 0, 0));
    step("halt_t3", 0, 1, 0, IR_HALT, mk(0, 0, 0, 0, 1, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      step("halt_hold", k[0], k[1], 0, IR_ADD, mk(0, 0, 0, 0, 0, 1, 0, 0));
    step("halt_clr", 1, 1, 1, IR_ADD, mk(0, 0, 0, 0, 0, 1, 0, 0));
    step("halt_exit", 0, 1, 0, IR_ADD, zero);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  in  1  datapath clock; all state changes on rising edge.
REQ-002 clear  in  1  synchronous active-high reset, same net as datapath clear.
REQ-003 run  in  1  level; in IDLE, a sampled 1 starts instruction fetch.
REQ-004 ir  in  32  IR register contents; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-005 mem_ready  in  1  memory data valid on Mdatain this cycle.
REQ-006 PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes, active-high.
REQ-007 R_in  out  16  one-hot GPR write enables (bit n drives Rnin).
REQ-008 R_out  out  16  one-hot GPR bus drives (bit n drives Rnout).
REQ-009 ALU_Control  out  5  ALU operation select.
REQ-010 busy  out  1  high in any state except IDLE and HALT.
REQ-011 halted  out  1  high in HALT.
REQ-012 instr_done  out  1  one-cycle pulse on the final step of each completed instruction.
REQ-013 illegal  out  1  one-cycle pulse when an undecodable opcode is detected in T3.

Function
REQ-014 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; every strobe not listed for a state is 0.
REQ-015 IDLE: run=1 -> T0; else stay.
REQ-016 T0: PCout, MARin, IncPC, Zin; -> T1.
REQ-017 T1, mem_ready=0: Read only; stay in T1 (unbounded stall).
REQ-018 T1, mem_ready=1: Zlowout, PCin, Read, MDRin; -> T2.
REQ-019 T2: MDRout, IRin; -> T3.
REQ-020 T3 decode: ALU op (opcode 00011..01101) or MUL/DIV (01110/01111) -> R_out[rb], Yin, -> T4; NOP (11010) -> instr_done, -> T0; HALT (11011) -> instr_done, -> HALT; any other -> illegal, -> T0.
REQ-021 T4: R_out[rc], Zin, ALU_Control=opcode; -> T5.
REQ-022 T5 ALU op: Zlowout, R_in[ra], instr_done; -> T0.
REQ-023 T5 MUL/DIV: Zlowout, LOin; -> T6.
REQ-024 T6: Zhighout, HIin, instr_done; -> T0.
REQ-025 HALT: all strobes 0; exited only by clear.
REQ-026 run is sampled only in IDLE; dropping run mid-instruction has no effect and execution continues across instructions until HALT.
REQ-027 R_in and R_out are never both nonzero, and at most one bus-driving strobe (PCout, Zlowout, Zhighout, MDRout, any R_out bit) is high per cycle.
REQ-028 ALU instruction latency: 6 cycles T0..T5 with mem_ready=1 in T1, plus 1 per stall cycle; MUL/DIV: 7 cycles.
REQ-029 All outputs are registered or decoded from the state register only; none depends combinationally on run or mem_ready, except the T1 strobes, which depend on mem_ready.

Reset
REQ-030 clear=1 at a rising edge -> IDLE, with priority over every transition, including mid-instruction and mid-stall.
REQ-031 In IDLE after reset, all outputs are 0: strobes, R_in, R_out, ALU_Control, busy, halted, instr_done, illegal.

Configuration
REQ-032 Macro MULDIV_EN defined: opcodes 01110/01111 follow REQ-020/023/024.
REQ-033 MULDIV_EN undefined: 01110/01111 are illegal (REQ-020 illegal path); T6 and the LOin/HIin logic are not synthesized, and HIin and LOin are tied 0.

Verification
REQ-034 clear, run=1, mem_ready=1, ir=add (00011, ra=3, rb=1, rc=2) -> T0..T5 in 6 cycles; T3 R_out=0x0002 with Yin; T4 R_out=0x0004 with ALU_Control=00011; T5 R_in=0x0008 with instr_done.
REQ-035 mem_ready held 0 for 3 cycles in T1 -> Read high for 4 cycles; PCin and MDRin only in the 4th cycle; instr_done at cycle 9.
REQ-036 MULDIV_EN defined, ir=mul (01110, rb=4, rc=5) -> T5 Zlowout+LOin, T6 Zhighout+HIin+instr_done; undefined -> illegal pulse in T3, next state T0.
REQ-037 ir opcode 11111 -> illegal pulse in T3, no R_in bit set, fetch restarts; ir=11011 -> halted=1, busy=0, held while run toggles.
REQ-038 clear asserted in T4 -> next cycle IDLE with all outputs 0; run=1 -> restart at T0.
